// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state encoding and width.
package mult_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;

endpackage

// File: rtl/mult_cond_neg.sv
// Combinational conditional two's-complement negate: out = en ? -in : in.
module mult_cond_neg #(
  parameter int N = 10
) (
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  assign out = en ? (~in + 1'b1) : in;

endmodule

// File: rtl/mult_seq_param.sv
// Parametrised shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Define MULT_DEBUG_EN to expose the live accumulator (ACC) and FSM state (pstate).
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               St,
  input  logic               Signed_Mode,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic [2*WIDTH-1:0] Prod,
  output logic               done,
  output logic               busy
`ifdef MULT_DEBUG_EN
  ,
  output logic [2*WIDTH:0]   ACC,
  output logic [1:0]         pstate
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   mcand_mag;
  logic               neg;

  logic [WIDTH-1:0]   mplier_abs;
  logic [WIDTH-1:0]   mcand_abs;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   acc_step;

  mult_cond_neg #(.N(WIDTH)) u_abs_mplier (
    .en  (Signed_Mode & Mplier[WIDTH-1]),
    .in  (Mplier),
    .out (mplier_abs)
  );

  mult_cond_neg #(.N(WIDTH)) u_abs_mcand (
    .en  (Signed_Mode & Mcand[WIDTH-1]),
    .in  (Mcand),
    .out (mcand_abs)
  );

  mult_cond_neg #(.N(2*WIDTH)) u_sign_result (
    .en  (neg),
    .in  (acc[2*WIDTH-1:0]),
    .out (result)
  );

  // Upper half keeps its carry bit so the shift brings it back into range.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand_mag} : '0);
    acc_step  = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      mcand_mag <= '0;
      neg       <= 1'b0;
      Prod      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (St) begin
            acc       <= {{(WIDTH+1){1'b0}}, mplier_abs};
            mcand_mag <= mcand_abs;
            neg       <= Signed_Mode & (Mplier[WIDTH-1] ^ Mcand[WIDTH-1]);
            count     <= '0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          Prod  <= result;
          done  <= 1'b1;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MULT_DEBUG_EN
  assign ACC    = acc;
  assign pstate = state;
`endif

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param at WIDTH=10 and WIDTH=16 against an arithmetic model.
// Build with and without MULT_DEBUG_EN.
module tb_mult_seq_param;

  localparam int W  = 10;
  localparam int WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            st, sm;
  logic [W-1:0]    mplier, mcand;
  logic [2*W-1:0]  prod;
  logic            done, busy;

  logic            st_b, sm_b;
  logic [WB-1:0]   mplier_b, mcand_b;
  logic [2*WB-1:0] prod_b;
  logic            done_b, busy_b;

`ifdef MULT_DEBUG_EN
  logic [2*W:0]    acc_dbg;
  logic [1:0]      pstate_dbg;
  logic [2*WB:0]   acc_dbg_b;
  logic [1:0]      pstate_dbg_b;
`endif

  int errors = 0;
  int checks = 0;

  mult_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .St          (st),
    .Signed_Mode (sm),
    .Mplier      (mplier),
    .Mcand       (mcand),
    .Prod        (prod),
    .done        (done),
    .busy        (busy)
`ifdef MULT_DEBUG_EN
    ,
    .ACC         (acc_dbg),
    .pstate      (pstate_dbg)
`endif
  );

  mult_seq_param #(.WIDTH(WB)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .St          (st_b),
    .Signed_Mode (sm_b),
    .Mplier      (mplier_b),
    .Mcand       (mcand_b),
    .Prod        (prod_b),
    .done        (done_b),
    .busy        (busy_b)
`ifdef MULT_DEBUG_EN
    ,
    .ACC         (acc_dbg_b),
    .pstate      (pstate_dbg_b)
`endif
  );

  // Reference: interpret operands as signed or unsigned integers, multiply, wrap to 2w bits.
  function automatic longint ref_prod(input bit s_mode, input longint a, input longint b,
                                      input int w);
    longint sa = a;
    longint sb = b;
    if (s_mode && a[w-1]) sa = a - (longint'(1) << w);
    if (s_mode && b[w-1]) sb = b - (longint'(1) << w);
    return (sa * sb) & ((longint'(1) << (2*w)) - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one WIDTH=10 operation, scramble inputs afterwards, optionally poke St mid-run.
  task automatic applyStimulus(input bit s_mode, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit poke);
    logic [63:0] expv;
    int n;
    bit got;
    expv   = 64'(ref_prod(s_mode, longint'(a), longint'(b), W));
    st     = 1'b1;
    sm     = s_mode;
    mplier = a;
    mcand  = b;
    @(posedge clk); #1;
    st     = 1'b0;
    sm     = 1'($urandom);
    mplier = W'($urandom);
    mcand  = W'($urandom);
    checkOutput("busy_start", 64'(busy), 64'd1);
    got = 1'b0;
    for (n = 1; n <= 3*W; n++) begin
      if (poke && n == 4) st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("latency", 64'(n), 64'(W + 1));
      checkOutput("prod", 64'(prod), expv);
      checkOutput("busy_at_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic applyStimulusWide(input bit s_mode, input logic [WB-1:0] a,
                                   input logic [WB-1:0] b);
    logic [63:0] expv;
    int n;
    bit got;
    expv     = 64'(ref_prod(s_mode, longint'(a), longint'(b), WB));
    st_b     = 1'b1;
    sm_b     = s_mode;
    mplier_b = a;
    mcand_b  = b;
    @(posedge clk); #1;
    st_b     = 1'b0;
    mplier_b = WB'($urandom);
    mcand_b  = WB'($urandom);
    got = 1'b0;
    for (n = 1; n <= 3*WB; n++) begin
      @(posedge clk); #1;
      if (done_b) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("w16_done_seen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("w16_latency", 64'(n), 64'(WB + 1));
      checkOutput("w16_prod", 64'(prod_b), expv);
    end
  endtask

  // No stray done pulse and Prod held for num cycles.
  task automatic idleCheck(input string tag, input int num);
    logic [2*W-1:0] held;
    bit bad;
    held = prod;
    bad  = 1'b0;
    repeat (num) begin
      @(posedge clk); #1;
      if (done || prod !== held) bad = 1'b1;
    end
    checkOutput(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    st = 1'b0; sm = 1'b0; mplier = '0; mcand = '0;
    st_b = 1'b0; sm_b = 1'b0; mplier_b = '0; mcand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_prod", 64'(prod), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_prod_w16", 64'(prod_b), 64'd0);
`ifdef MULT_DEBUG_EN
    checkOutput("rst_acc", 64'(acc_dbg), 64'd0);
    checkOutput("rst_pstate", 64'(pstate_dbg), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 10'h3FF, 10'h3FF, 1'b0);
    checkOutput("max_unsigned", 64'(prod), 64'hFF801);
    idleCheck("hold_after_done", 3);
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 1'b0);
    checkOutput("neg1_sq", 64'(prod), 64'h00001);
    applyStimulus(1'b1, 10'h200, 10'h200, 1'b0);
    checkOutput("min_sq", 64'(prod), 64'h40000);
    applyStimulus(1'b1, 10'h200, 10'h1FF, 1'b0);
    checkOutput("min_x_max_signed", 64'(prod), 64'hC0200);
    applyStimulus(1'b0, 10'h200, 10'h1FF, 1'b0);
    checkOutput("min_x_max_unsigned", 64'(prod), 64'h3FE00);

    $display("[TB] St while busy, then back-to-back start in done cycle");
    applyStimulus(1'b0, 10'd37, 10'd29, 1'b1);
    idleCheck("no_queued_op", 15);
    applyStimulus(1'b1, 10'h155, 10'h2AA, 1'b0);
    applyStimulus(1'b0, 10'd1000, 10'd3, 1'b0);

    $display("[TB] reset mid-operation");
    st = 1'b1; sm = 1'b0; mplier = 10'd999; mcand = 10'd777;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_prod", 64'(prod), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    idleCheck("abort_no_done", 15);
    applyStimulus(1'b0, 10'd0, 10'd1023, 1'b0);
    checkOutput("zero_operand", 64'(prod), 64'd0);

    $display("[TB] random cases");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("[TB] WIDTH=16 instance");
    applyStimulusWide(1'b0, 16'hFFFF, 16'hFFFF);
    checkOutput("w16_max_unsigned", 64'(prod_b), 64'hFFFE0001);
    applyStimulusWide(1'b1, 16'h8000, 16'h8000);
    for (int i = 0; i < 6; i++) begin
      applyStimulusWide(1'($urandom), WB'($urandom), WB'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
